udma_rx_l2_writer: RTL and testbench

//  Multi-channel RX DMA write engine: peripherals push bytes/halfwords/words, the block arbitrates them, generates linear L2 addresses per channel and

---
 rtl/udma_rx_l2_writer_if.sv | 14 +
 rtl/udma_rx_l2_writer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_udma_rx_l2_writer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udma_rx_l2_writer_if.sv
// L2 write-request bus between the RX write engine and the L2 interconnect.
// A request retires on the cycle where req and gnt are both high.
interface udma_rx_l2_writer_if #(
  parameter int L2_DATA_WIDTH = 32
) ();
  logic                         req;
  logic                         gnt;
  logic [31:0]                  addr;
  logic [L2_DATA_WIDTH-1:0]     wdata;
  logic [L2_DATA_WIDTH/8-1:0]   be;

  modport master (output req, addr, wdata, be, input gnt);
  modport slave  (input req, addr, wdata, be, output gnt);
endinterface

// File: rtl/udma_rx_l2_writer.sv
// Multi-channel RX DMA write engine: per-channel linear address generators,
// round-robin arbitration of peripheral beats into a write-request FIFO, and
// byte-lane formatting of the FIFO head onto the L2 write bus.

// One RX channel: address / bytes-left counters, pending reload slot and
// end-of-transfer event.
module udma_rx_ch #(
  parameter int AW = 20,
  parameter int TS = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [AW-1:0] cfg_startaddr_i,
  input  logic [TS-1:0] cfg_size_i,
  input  logic          cfg_continuous_i,
  input  logic          cfg_en_i,
  input  logic          cfg_clr_i,
  input  logic          accept_i,
  input  logic [1:0]    datasize_i,
  output logic          en_o,
  output logic          pending_o,
  output logic [AW-1:0] curr_addr_o,
  output logic [TS-1:0] bytes_left_o,
  output logic          event_o
);
  logic [TS-1:0] step;
  logic          last;
  logic [AW-1:0] lat_addr;
  logic [TS-1:0] lat_size;

  // Byte step of the current beat; size 3 behaves as a word.
  always_comb begin
    case (datasize_i)
      2'd0:    step = TS'(1);
      2'd1:    step = TS'(2);
      default: step = TS'(4);
    endcase
  end

  assign last = (bytes_left_o <= step);

  // Channel state: clear beats everything, then beat accounting, then start/queue.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_o         <= 1'b0;
      pending_o    <= 1'b0;
      curr_addr_o  <= '0;
      bytes_left_o <= '0;
      event_o      <= 1'b0;
      lat_addr     <= '0;
      lat_size     <= '0;
    end else begin
      event_o <= 1'b0;
      if (cfg_clr_i) begin
        en_o         <= 1'b0;
        pending_o    <= 1'b0;
        bytes_left_o <= '0;
      end else begin
        if (accept_i) begin
          curr_addr_o  <= curr_addr_o + AW'(step);
          bytes_left_o <= last ? '0 : bytes_left_o - step;
          event_o      <= last;
          if (last) begin
            if (pending_o) begin
              curr_addr_o  <= lat_addr;
              bytes_left_o <= lat_size;
              pending_o    <= 1'b0;
              en_o         <= (lat_size != '0);
            end else if (cfg_continuous_i) begin
              curr_addr_o  <= cfg_startaddr_i;
              bytes_left_o <= cfg_size_i;
              en_o         <= (cfg_size_i != '0);
            end else begin
              en_o <= 1'b0;
            end
          end
        end
        // A start arriving as the channel finishes (with nothing queued) is
        // taken directly instead of being parked in the pending slot.
        if (cfg_en_i) begin
          if (!en_o || (accept_i && last && !pending_o)) begin
            if (cfg_size_i != '0) begin
              en_o         <= 1'b1;
              curr_addr_o  <= cfg_startaddr_i;
              bytes_left_o <= cfg_size_i;
            end
          end else begin
            lat_addr  <= cfg_startaddr_i;
            lat_size  <= cfg_size_i;
            pending_o <= 1'b1;
          end
        end
      end
    end
  end
endmodule

module udma_rx_l2_writer #(
  parameter int L2_AWIDTH_NOAL = 20,
  parameter int L2_DATA_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int N_CHANNELS     = 4,
  parameter int TRANS_SIZE     = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rstn_i,
  udma_rx_l2_writer_if.master                            l2,
  input  logic [N_CHANNELS-1:0]                          ch_valid_i,
  input  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0]          ch_data_i,
  input  logic [N_CHANNELS-1:0][1:0]                     ch_datasize_i,
  input  logic [N_CHANNELS-1:0][1:0]                     ch_destination_i,
  output logic [N_CHANNELS-1:0]                          ch_ready_o,
  input  logic [N_CHANNELS-1:0][L2_AWIDTH_NOAL-1:0]      cfg_startaddr_i,
  input  logic [N_CHANNELS-1:0][TRANS_SIZE-1:0]          cfg_size_i,
  input  logic [N_CHANNELS-1:0]                          cfg_continuous_i,
  input  logic [N_CHANNELS-1:0]                          cfg_en_i,
  input  logic [N_CHANNELS-1:0]                          cfg_clr_i,
  output logic [N_CHANNELS-1:0]                          ch_en_o,
  output logic [N_CHANNELS-1:0]                          ch_pending_o,
  output logic [N_CHANNELS-1:0][L2_AWIDTH_NOAL-1:0]      ch_curr_addr_o,
  output logic [N_CHANNELS-1:0][TRANS_SIZE-1:0]          ch_bytes_left_o,
  output logic [N_CHANNELS-1:0]                          ch_events_o
);
  localparam int NB    = L2_DATA_WIDTH / 8;
  localparam int ALIGN = $clog2(NB);
  localparam int CHW   = $clog2(N_CHANNELS);
  localparam int CHW1  = CHW + 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [1:0]                dest;
    logic [L2_AWIDTH_NOAL-1:0] addr;
    logic [1:0]                size;
    logic [DATA_WIDTH-1:0]     data;
  } l2_entry_t;

  logic [N_CHANNELS-1:0] arb_req;
  logic [N_CHANNELS-1:0] grant;
  logic [CHW-1:0]        rr_ptr;
  logic [CHW-1:0]        win;
  logic [CHW1-1:0]       arb_sum;
  logic                  found;

  l2_entry_t             fifo_q [FIFO_DEPTH];
  l2_entry_t             new_e;
  l2_entry_t             head;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  fifo_full, push, pop;

  logic [31:0]           addr_al;
  logic [ALIGN-1:0]      off;
  logic [NB-1:0]         be;
  logic [L2_DATA_WIDTH-1:0] wdata;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_ch
    udma_rx_ch #(.AW(L2_AWIDTH_NOAL), .TS(TRANS_SIZE)) u_ch (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .cfg_startaddr_i  (cfg_startaddr_i[g]),
      .cfg_size_i       (cfg_size_i[g]),
      .cfg_continuous_i (cfg_continuous_i[g]),
      .cfg_en_i         (cfg_en_i[g]),
      .cfg_clr_i        (cfg_clr_i[g]),
      .accept_i         (grant[g]),
      .datasize_i       (ch_datasize_i[g]),
      .en_o             (ch_en_o[g]),
      .pending_o        (ch_pending_o[g]),
      .curr_addr_o      (ch_curr_addr_o[g]),
      .bytes_left_o     (ch_bytes_left_o[g]),
      .event_o          (ch_events_o[g])
    );
  end

  assign arb_req    = ch_valid_i & ch_en_o;
  assign fifo_full  = (cnt == CW'(FIFO_DEPTH));
  assign ch_ready_o = grant;

  // Round-robin: scan from rr_ptr upward, first requester wins; a full FIFO
  // blocks all grants even if the head retires this cycle.
  always_comb begin
    grant   = '0;
    win     = '0;
    found   = 1'b0;
    arb_sum = '0;
    for (int i = 0; i < N_CHANNELS; i++) begin
      arb_sum = {1'b0, rr_ptr} + CHW1'(i);
      if (arb_sum >= CHW1'(N_CHANNELS)) arb_sum = arb_sum - CHW1'(N_CHANNELS);
      if (!found && arb_req[arb_sum[CHW-1:0]] && !fifo_full) begin
        found                   = 1'b1;
        win                     = arb_sum[CHW-1:0];
        grant[arb_sum[CHW-1:0]] = 1'b1;
      end
    end
  end

  // Priority moves to the channel after the last winner.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)    rr_ptr <= '0;
    else if (found) rr_ptr <= (win == CHW'(N_CHANNELS - 1)) ? '0 : win + CHW'(1);
  end

  assign push = found;
  assign pop  = l2.req & l2.gnt;

  // Snapshot of the winning beat as it enters the FIFO.
  always_comb begin
    new_e.dest = ch_destination_i[win];
    new_e.addr = ch_curr_addr_o[win];
    new_e.size = ch_datasize_i[win];
    new_e.data = ch_data_i[win];
  end

  // Write-request FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= new_e;
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = fifo_q[rd_ptr];

  // Head formatting: region prefix, bus-aligned address, lane replication, byte enables.
  always_comb begin
    addr_al             = 32'(head.addr);
    addr_al[ALIGN-1:0]  = '0;
    case (head.dest)
      2'b01:   addr_al[31:20] = 12'h1A1;
      2'b10:   addr_al[31:24] = 8'h10;
      default: addr_al[31:24] = 8'h1C;
    endcase
    off = head.addr[ALIGN-1:0];
    case (head.size)
      2'd0: begin
        be    = NB'(1) << off;
        wdata = {NB{head.data[7:0]}};
      end
      2'd1: begin
        off[0] = 1'b0;
        be     = NB'(2'b11) << off;
        wdata  = {(NB/2){head.data[15:0]}};
      end
      default: begin
        off[1:0] = 2'b00;
        be       = NB'(4'hF) << off;
        wdata    = {(NB/4){head.data[31:0]}};
      end
    endcase
  end

  assign l2.req   = (cnt != '0);
  assign l2.addr  = addr_al;
  assign l2.wdata = wdata;
  assign l2.be    = be;
endmodule

// File: tb/tb_udma_rx_l2_writer.sv
// Directed bench for udma_rx_l2_writer: channel counters, events, arbitration,
// FIFO back-pressure, continuous/pending reloads, clear and reset.
module tb_udma_rx_l2_writer;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  udma_rx_l2_writer_if #(.L2_DATA_WIDTH(32)) l2_if ();

  logic [N-1:0]        valid, ready, cont, cen, clr, ch_en, pend, ev;
  logic [N-1:0][31:0]  data;
  logic [N-1:0][1:0]   dsize, dest;
  logic [N-1:0][19:0]  saddr, caddr;
  logic [N-1:0][15:0]  csize, bleft;

  udma_rx_l2_writer dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .l2               (l2_if),
    .ch_valid_i       (valid),
    .ch_data_i        (data),
    .ch_datasize_i    (dsize),
    .ch_destination_i (dest),
    .ch_ready_o       (ready),
    .cfg_startaddr_i  (saddr),
    .cfg_size_i       (csize),
    .cfg_continuous_i (cont),
    .cfg_en_i         (cen),
    .cfg_clr_i        (clr),
    .ch_en_o          (ch_en),
    .ch_pending_o     (pend),
    .ch_curr_addr_o   (caddr),
    .ch_bytes_left_o  (bleft),
    .ch_events_o      (ev)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t wr_q[$];
  int  gnt_q[$];
  wr_t mon_w;
  int  n_chk = 0;
  int  n_err = 0;

  // Log retired L2 writes and arbitration winners at each clock edge.
  always @(posedge clk) begin
    if (l2_if.req && l2_if.gnt) begin
      mon_w.a  = l2_if.addr;
      mon_w.d  = l2_if.wdata;
      mon_w.be = l2_if.be;
      wr_q.push_back(mon_w);
    end
    for (int i = 0; i < N; i++) if (ready[i]) gnt_q.push_back(i);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_ch(input logic [1:0] ch, input logic [19:0] a, input logic [15:0] s, input logic c);
    saddr[ch] = a;
    csize[ch] = s;
    cont[ch]  = c;
    cen[ch]   = 1'b1;
    tick();
    cen[ch]   = 1'b0;
  endtask

  task automatic clear_ch(input logic [1:0] ch);
    clr[ch] = 1'b1;
    tick();
    clr[ch] = 1'b0;
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] d, input logic [1:0] sz);
    int k;
    valid[ch] = 1'b1;
    data[ch]  = d;
    dsize[ch] = sz;
    #1;
    k = 0;
    while (!ready[ch] && k < 50) begin
      tick();
      #1;
      k++;
    end
    check("push_ready", ready[ch], 1'b1);
    tick();
    valid[ch] = 1'b0;
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    if (idx < wr_q.size()) begin
      check({tag, "_addr"}, wr_q[idx].a, a);
      check({tag, "_data"}, wr_q[idx].d, d);
      check({tag, "_be"},   wr_q[idx].be, be);
    end else begin
      check({tag, "_missing"}, wr_q.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    logic r;
    rstn = 1'b0;
    valid = '0; cont = '0; cen = '0; clr = '0;
    data = '0; dsize = '0; dest = '0; saddr = '0; csize = '0;
    l2_if.gnt = 1'b1;
    tick();
    #1;
    check("rst_req",   l2_if.req, 1'b0);
    check("rst_ready", ready, 4'h0);
    check("rst_en",    ch_en, 4'h0);
    check("rst_bleft", bleft, 64'h0);
    tick();
    rstn = 1'b1;
    tick();

    // T1: two word beats on ch0
    wr_q.delete();
    start_ch(0, 20'h100, 16'd8, 1'b0);
    check("t1_en", ch_en[0], 1'b1);
    push(0, 32'hA5A5_0001, 2'd2);
    check("t1_addr1",  caddr[0], 20'h104);
    check("t1_bleft1", bleft[0], 16'd4);
    check("t1_req",    l2_if.req, 1'b1);
    check("t1_l2addr", l2_if.addr, 32'h1C00_0100);
    push(0, 32'h1234_5678, 2'd2);
    check("t1_event",  ev[0], 1'b1);
    check("t1_en_off", ch_en[0], 1'b0);
    check("t1_bleft2", bleft[0], 16'd0);
    tick();
    check("t1_event_1cyc", ev[0], 1'b0);
    repeat (3) tick();
    check("t1_nwr", wr_q.size(), 2);
    check_wr("t1_w0", 0, 32'h1C00_0100, 32'hA5A5_0001, 4'hF);
    check_wr("t1_w1", 1, 32'h1C00_0104, 32'h1234_5678, 4'hF);

    // T2: byte and halfword lanes
    wr_q.delete();
    start_ch(1, 20'h201, 16'd3, 1'b0);
    push(1, 32'hABCD_EF11, 2'd0);
    push(1, 32'hABCD_EF22, 2'd0);
    push(1, 32'hABCD_EF33, 2'd0);
    check("t2_event", ev[1], 1'b1);
    dest[1] = 2'b01;
    start_ch(1, 20'h202, 16'd2, 1'b0);
    push(1, 32'h1234_BEEF, 2'd1);
    check("t2_half_event", ev[1], 1'b1);
    repeat (3) tick();
    check("t2_nwr", wr_q.size(), 4);
    check_wr("t2_b1", 0, 32'h1C00_0200, 32'h1111_1111, 4'h2);
    check_wr("t2_b2", 1, 32'h1C00_0200, 32'h2222_2222, 4'h4);
    check_wr("t2_b3", 2, 32'h1C00_0200, 32'h3333_3333, 4'h8);
    check_wr("t2_h",  3, 32'h1A10_0200, 32'hBEEF_BEEF, 4'hC);
    dest[1] = 2'b00;

    // T3: round-robin with all channels requesting
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    start_ch(0, 20'h1000, 16'h40, 1'b0);
    start_ch(1, 20'h2000, 16'h40, 1'b0);
    start_ch(2, 20'h3000, 16'h40, 1'b0);
    start_ch(3, 20'h4000, 16'h40, 1'b0);
    wr_q.delete();
    gnt_q.delete();
    for (int i = 0; i < N; i++) begin
      data[i]  = 32'h30 + i;
      dsize[i] = 2'd2;
    end
    valid = 4'hF;
    repeat (8) tick();
    valid = 4'h0;
    repeat (4) tick();
    check("t3_ngnt", gnt_q.size(), 8);
    for (int i = 0; i < 8 && i < gnt_q.size(); i++)
      check($sformatf("t3_gnt%0d", i), gnt_q[i], i % 4);
    for (int i = 0; i < N; i++)
      check($sformatf("t3_bleft%0d", i), bleft[i], 16'h38);
    check_wr("t3_w0", 0, 32'h1C00_1000, 32'h30, 4'hF);
    check_wr("t3_w1", 1, 32'h1C00_2000, 32'h31, 4'hF);
    check_wr("t3_w4", 4, 32'h1C00_1004, 32'h30, 4'hF);
    check_wr("t3_w7", 7, 32'h1C00_4004, 32'h33, 4'hF);

    // T4: back-pressure fills the FIFO
    wr_q.delete();
    l2_if.gnt = 1'b0;
    acc = 0;
    valid[0] = 1'b1;
    data[0]  = 32'hD000_0000;
    for (int c = 0; c < 10; c++) begin
      #1;
      r = ready[0];
      tick();
      if (r) begin
        acc++;
        data[0] = 32'hD000_0000 + acc;
      end
    end
    #1;
    check("t4_acc",     acc, 4);
    check("t4_ready",   ready, 4'h0);
    check("t4_req",     l2_if.req, 1'b1);
    check("t4_addr",    l2_if.addr, 32'h1C00_1008);
    check("t4_wdata",   l2_if.wdata, 32'hD000_0000);
    check("t4_nwr_hold", wr_q.size(), 0);
    valid[0] = 1'b0;
    l2_if.gnt = 1'b1;
    repeat (6) tick();
    check("t4_nwr", wr_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check_wr($sformatf("t4_w%0d", i), i, 32'h1C00_1008 + 4 * i, 32'hD000_0000 + i, 4'hF);
    check("t4_bleft", bleft[0], 16'h28);

    // T5a: pending reload
    clear_ch(1);
    check("t5_clr_en", ch_en[1], 1'b0);
    start_ch(1, 20'h500, 16'd4, 1'b0);
    start_ch(1, 20'h600, 16'd4, 1'b0);
    check("t5_pend",      pend[1], 1'b1);
    check("t5_pend_addr", caddr[1], 20'h500);
    push(1, 32'h55, 2'd2);
    check("t5_pend_ev",    ev[1], 1'b1);
    check("t5_pend_en",    ch_en[1], 1'b1);
    check("t5_pend_raddr", caddr[1], 20'h600);
    check("t5_pend_bleft", bleft[1], 16'd4);
    check("t5_pend_clr",   pend[1], 1'b0);
    repeat (3) tick();

    // T5b: continuous reload
    wr_q.delete();
    clear_ch(2);
    dest[2] = 2'b10;
    start_ch(2, 20'h300, 16'd4, 1'b1);
    for (int i = 0; i < 2; i++) begin
      push(2, 32'hC0FF_EE00 + i, 2'd2);
      check($sformatf("t5_cev%0d", i),   ev[2], 1'b1);
      check($sformatf("t5_cen%0d", i),   ch_en[2], 1'b1);
      check($sformatf("t5_cbl%0d", i),   bleft[2], 16'd4);
      check($sformatf("t5_caddr%0d", i), caddr[2], 20'h300);
    end
    cont[2] = 1'b0;
    repeat (3) tick();
    check("t5_nwr", wr_q.size(), 2);
    check_wr("t5_w0", 0, 32'h1000_0300, 32'hC0FF_EE00, 4'hF);
    check_wr("t5_w1", 1, 32'h1000_0300, 32'hC0FF_EE01, 4'hF);

    // T6: clear with queued entries, size-0 start, reset mid-operation
    l2_if.gnt = 1'b0;
    push(3, 32'hE0, 2'd2);
    push(3, 32'hE1, 2'd2);
    check("t6_bleft", bleft[3], 16'h30);
    clear_ch(3);
    check("t6_clr_en",    ch_en[3], 1'b0);
    check("t6_clr_bleft", bleft[3], 16'h0);
    check("t6_clr_pend",  pend[3], 1'b0);
    gnt_q.delete();
    valid[3] = 1'b1;
    repeat (3) tick();
    #1;
    check("t6_no_ready", ready[3], 1'b0);
    check("t6_no_gnt",   gnt_q.size(), 0);
    valid[3] = 1'b0;
    wr_q.delete();
    l2_if.gnt = 1'b1;
    repeat (4) tick();
    check("t6_nwr", wr_q.size(), 2);
    check_wr("t6_w0", 0, 32'h1C00_4008, 32'hE0, 4'hF);
    check_wr("t6_w1", 1, 32'h1C00_400C, 32'hE1, 4'hF);
    start_ch(3, 20'h700, 16'd0, 1'b0);
    check("t6_size0_en", ch_en[3], 1'b0);
    tick();
    check("t6_size0_ev", ev[3], 1'b0);
    start_ch(3, 20'h800, 16'd8, 1'b0);
    l2_if.gnt = 1'b0;
    push(3, 32'hF00D, 2'd2);
    check("t6_pre_rst_req", l2_if.req, 1'b1);
    rstn = 1'b0;
    #1;
    check("t6_rst_req",   l2_if.req, 1'b0);
    check("t6_rst_en",    ch_en, 4'h0);
    check("t6_rst_bleft", bleft[3], 16'h0);
    check("t6_rst_addr",  caddr[3], 20'h0);
    tick();
    rstn = 1'b1;
    tick();
    check("t6_post_rst_req", l2_if.req, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
